// File: rtl/ysyx_25040109_axi_xbar_n_if.sv
// Upstream AXI4 bus (core side) and downstream N-slave fan-out bundle for the crossbar.
// Downstream response payloads are flattened N_SLV x field width.
interface ysyx_25040109_axi_xbar_n_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid, rready, rlast;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic [ID_W-1:0]   rid;
  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [ID_W-1:0]   awid;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              wvalid, wready, wlast;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic              bvalid, bready;
  logic [1:0]        bresp;
  logic [ID_W-1:0]   bid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
           awvalid, awaddr, awid, awlen, awsize, awburst,
           wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rresp, rid, rlast, awready, wready, bvalid, bresp, bid
  );
  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
           awvalid, awaddr, awid, awlen, awsize, awburst,
           wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rresp, rid, rlast, awready, wready, bvalid, bresp, bid
  );
endinterface

interface ysyx_25040109_axi_xbar_n_dn_if #(
  parameter int N_SLV  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [N_SLV-1:0]        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [N_SLV-1:0]        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [ADDR_W-1:0]       m_araddr, m_awaddr;
  logic [ID_W-1:0]         m_arid, m_awid;
  logic [7:0]              m_arlen, m_awlen;
  logic [2:0]              m_arsize, m_awsize;
  logic [1:0]              m_arburst, m_awburst;
  logic [DATA_W-1:0]       m_wdata;
  logic [DATA_W/8-1:0]     m_wstrb;
  logic                    m_wlast;
  logic [N_SLV*DATA_W-1:0] m_rdata;
  logic [N_SLV*2-1:0]      m_rresp, m_bresp;
  logic [N_SLV*ID_W-1:0]   m_rid, m_bid;

  modport master (
    output m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
           m_araddr, m_arid, m_arlen, m_arsize, m_arburst,
           m_awaddr, m_awid, m_awlen, m_awsize, m_awburst, m_wdata, m_wstrb, m_wlast,
    input  m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid,
           m_rdata, m_rresp, m_rid, m_bresp, m_bid
  );
  modport slave (
    input  m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready,
           m_araddr, m_arid, m_arlen, m_arsize, m_arburst,
           m_awaddr, m_awid, m_awlen, m_awsize, m_awburst, m_wdata, m_wstrb, m_wlast,
    output m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid,
           m_rdata, m_rresp, m_rid, m_bresp, m_bid
  );
endinterface

// File: rtl/ysyx_25040109_axi_xbar_n.sv
// 1-to-N AXI4 crossbar: independent read/write address decode, combinational routing,
// and burst-length-aware DECERR for unmapped or illegal (burst to simple slave) accesses.
module ysyx_25040109_axi_xbar_n #(
  parameter int N_SLV  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter logic [N_SLV*ADDR_W-1:0] SLV_BASE   = {32'h10010000, 32'h10000000, 32'h80000000},
  parameter logic [N_SLV*ADDR_W-1:0] SLV_MASK   = {32'hFFFFFFF8, 32'hFFFFFFF0, 32'hF8000000},
  parameter logic [N_SLV-1:0]        SLV_SIMPLE = 3'b110
) (
  input  logic clk,
  input  logic rst_n,
  ysyx_25040109_axi_xbar_n_if.slave     up,
  ysyx_25040109_axi_xbar_n_dn_if.master dn
);
  localparam int         SEL_W     = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam logic [2:0] FULL_SIZE = 3'($clog2(DATA_W/8));

  typedef enum logic [1:0] {R_IDLE, R_FWD, R_ERR} rd_state_t;
  typedef enum logic [2:0] {W_IDLE, W_FWD, W_SINK, W_RESP, W_ERRB} wr_state_t;

  rd_state_t        r_rd_state;
  wr_state_t        r_wr_state;
  logic [SEL_W-1:0] r_rd_sel, r_wr_sel;
  logic [ID_W-1:0]  r_rd_id, r_wr_id;
  logic [7:0]       r_rd_cnt;

  logic [N_SLV-1:0]  w_ar_hits, w_aw_hits;
  logic              w_ar_hit, w_aw_hit;
  logic [SEL_W-1:0]  w_ar_sel, w_aw_sel;
  logic [DATA_W-1:0] w_rdata [N_SLV];
  logic [1:0]        w_rresp [N_SLV];
  logic [1:0]        w_bresp [N_SLV];
  logic [ID_W-1:0]   w_rid   [N_SLV];
  logic [ID_W-1:0]   w_bid   [N_SLV];

  genvar gi;
  generate
    for (gi = 0; gi < N_SLV; gi++) begin : g_slv
      localparam logic [ADDR_W-1:0] BASE = SLV_BASE[gi*ADDR_W +: ADDR_W];
      localparam logic [ADDR_W-1:0] MASK = SLV_MASK[gi*ADDR_W +: ADDR_W];
      // Simple slaves only match single-beat, full-width INCR accesses; anything else is a DECERR.
      assign w_ar_hits[gi] = ((up.araddr & MASK) == BASE) && (!SLV_SIMPLE[gi] ||
                             (up.arlen == 8'd0 && up.arsize == FULL_SIZE && up.arburst == 2'b01));
      assign w_aw_hits[gi] = ((up.awaddr & MASK) == BASE) && (!SLV_SIMPLE[gi] ||
                             (up.awlen == 8'd0 && up.awsize == FULL_SIZE && up.awburst == 2'b01));
      assign w_rdata[gi] = dn.m_rdata[gi*DATA_W +: DATA_W];
      assign w_rresp[gi] = dn.m_rresp[gi*2 +: 2];
      assign w_rid[gi]   = dn.m_rid[gi*ID_W +: ID_W];
      assign w_bresp[gi] = dn.m_bresp[gi*2 +: 2];
      assign w_bid[gi]   = dn.m_bid[gi*ID_W +: ID_W];
    end
  endgenerate

  function automatic logic [SEL_W-1:0] f_first(input logic [N_SLV-1:0] hits);
    f_first = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if (hits[i]) f_first = SEL_W'(i);
    end
  endfunction

  assign w_ar_hit = |w_ar_hits;
  assign w_aw_hit = |w_aw_hits;
  assign w_ar_sel = f_first(w_ar_hits);
  assign w_aw_sel = f_first(w_aw_hits);

  assign dn.m_araddr  = up.araddr;
  assign dn.m_arid    = up.arid;
  assign dn.m_arlen   = up.arlen;
  assign dn.m_arsize  = up.arsize;
  assign dn.m_arburst = up.arburst;
  assign dn.m_awaddr  = up.awaddr;
  assign dn.m_awid    = up.awid;
  assign dn.m_awlen   = up.awlen;
  assign dn.m_awsize  = up.awsize;
  assign dn.m_awburst = up.awburst;
  assign dn.m_wdata   = up.wdata;
  assign dn.m_wstrb   = up.wstrb;
  assign dn.m_wlast   = up.wlast;

  // Read routing; everything stays 0 while rst_n is low.
  always_comb begin
    dn.m_arvalid = '0;
    dn.m_rready  = '0;
    up.arready   = 1'b0;
    up.rvalid    = 1'b0;
    up.rdata     = '0;
    up.rresp     = 2'b00;
    up.rid       = '0;
    up.rlast     = 1'b0;
    if (rst_n) begin
      case (r_rd_state)
        R_IDLE: begin
          if (w_ar_hit) begin
            dn.m_arvalid[w_ar_sel] = up.arvalid;
            up.arready             = dn.m_arready[w_ar_sel];
          end else begin
            up.arready = 1'b1;
          end
        end
        R_FWD: begin
          up.rvalid            = dn.m_rvalid[r_rd_sel];
          up.rdata             = w_rdata[r_rd_sel];
          up.rresp             = w_rresp[r_rd_sel];
          up.rid               = w_rid[r_rd_sel];
          up.rlast             = dn.m_rlast[r_rd_sel];
          dn.m_rready[r_rd_sel] = up.rready;
        end
        R_ERR: begin
          up.rvalid = 1'b1;
          up.rresp  = 2'b11;
          up.rid    = r_rd_id;
          up.rlast  = (r_rd_cnt == 8'd0);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dn.m_awvalid = '0;
    dn.m_wvalid  = '0;
    dn.m_bready  = '0;
    up.awready   = 1'b0;
    up.wready    = 1'b0;
    up.bvalid    = 1'b0;
    up.bresp     = 2'b00;
    up.bid       = '0;
    if (rst_n) begin
      case (r_wr_state)
        W_IDLE: begin
          if (w_aw_hit) begin
            dn.m_awvalid[w_aw_sel] = up.awvalid;
            up.awready             = dn.m_awready[w_aw_sel];
          end else begin
            up.awready = 1'b1;
          end
        end
        W_FWD: begin
          dn.m_wvalid[r_wr_sel] = up.wvalid;
          up.wready             = dn.m_wready[r_wr_sel];
        end
        W_SINK: up.wready = 1'b1;
        W_RESP: begin
          up.bvalid             = dn.m_bvalid[r_wr_sel];
          up.bresp              = w_bresp[r_wr_sel];
          up.bid                = w_bid[r_wr_sel];
          dn.m_bready[r_wr_sel] = up.bready;
        end
        W_ERRB: begin
          up.bvalid = 1'b1;
          up.bresp  = 2'b11;
          up.bid    = r_wr_id;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_state <= R_IDLE;
      r_rd_sel   <= '0;
      r_rd_id    <= '0;
      r_rd_cnt   <= 8'd0;
    end else begin
      case (r_rd_state)
        R_IDLE: if (up.arvalid && up.arready) begin
          r_rd_sel   <= w_ar_sel;
          r_rd_id    <= up.arid;
          r_rd_cnt   <= up.arlen;
          r_rd_state <= w_ar_hit ? R_FWD : R_ERR;
        end
        R_FWD: if (up.rvalid && up.rready && up.rlast) r_rd_state <= R_IDLE;
        R_ERR: if (up.rready) begin
          if (r_rd_cnt == 8'd0) r_rd_state <= R_IDLE;
          else                  r_rd_cnt   <= r_rd_cnt - 8'd1;
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_state <= W_IDLE;
      r_wr_sel   <= '0;
      r_wr_id    <= '0;
    end else begin
      case (r_wr_state)
        W_IDLE: if (up.awvalid && up.awready) begin
          r_wr_sel   <= w_aw_sel;
          r_wr_id    <= up.awid;
          r_wr_state <= w_aw_hit ? W_FWD : W_SINK;
        end
        W_FWD:  if (up.wvalid && up.wready && up.wlast) r_wr_state <= W_RESP;
        W_SINK: if (up.wvalid && up.wlast)              r_wr_state <= W_ERRB;
        W_RESP: if (up.bvalid && up.bready)             r_wr_state <= W_IDLE;
        W_ERRB: if (up.bready)                          r_wr_state <= W_IDLE;
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25040109_axi_xbar_n.sv
// Directed bench for the 1-to-N AXI crossbar: decode table plus multi-cycle burst,
// DECERR, concurrent read/write and mid-burst reset sequences.
module tb_ysyx_25040109_axi_xbar_n;
  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ysyx_25040109_axi_xbar_n_if    #(.ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) up();
  ysyx_25040109_axi_xbar_n_dn_if #(.N_SLV(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dn();

  ysyx_25040109_axi_xbar_n #(.N_SLV(N), .ADDR_W(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .up   (up),
    .dn   (dn)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [2:0]  exp_mvalid;
    logic        exp_ready;
  } dec_vec_t;
  dec_vec_t vecs [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    up.arvalid = 0; up.araddr = 0; up.arid = 0; up.arlen = 0; up.arsize = 3'd2; up.arburst = 2'b01;
    up.rready = 0;
    up.awvalid = 0; up.awaddr = 0; up.awid = 0; up.awlen = 0; up.awsize = 3'd2; up.awburst = 2'b01;
    up.wvalid = 0; up.wdata = 0; up.wstrb = 0; up.wlast = 0; up.bready = 0;
    dn.m_arready = '0; dn.m_rvalid = '0; dn.m_rlast = '0; dn.m_rdata = '0; dn.m_rresp = '0;
    dn.m_rid = '0; dn.m_awready = '0; dn.m_wready = '0; dn.m_bvalid = '0; dn.m_bresp = '0;
    dn.m_bid = '0;
  endtask

  task automatic err_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input int stall_beat);
    @(negedge clk);
    up.arvalid = 1; up.araddr = addr; up.arlen = len; up.arid = id; up.arsize = 3'd2;
    up.arburst = 2'b01; dn.m_arready = '1; up.rready = 1;
    #1;
    chk("err_ar_mvalid", 64'(dn.m_arvalid), 64'd0);
    chk("err_arready", 64'(up.arready), 64'd1);
    @(negedge clk);
    up.arvalid = 0;
    for (int b = 0; b <= int'(len); b++) begin
      if (b == stall_beat) begin
        up.rready = 0;
        #1;
        chk("err_stall_rvalid", 64'(up.rvalid), 64'd1);
        chk("err_stall_rlast", 64'(up.rlast), 64'(b == int'(len)));
        @(negedge clk);
        up.rready = 1;
      end
      #1;
      chk("err_rvalid", 64'(up.rvalid), 64'd1);
      chk("err_rdata", 64'(up.rdata), 64'd0);
      chk("err_rresp", 64'(up.rresp), 64'd3);
      chk("err_rid", 64'(up.rid), 64'(id));
      chk("err_rlast", 64'(up.rlast), 64'(b == int'(len)));
      chk("err_m_arvalid", 64'(dn.m_arvalid), 64'd0);
      @(negedge clk);
    end
    up.araddr = 32'h2000_0000;
    #1;
    chk("err_done_rvalid", 64'(up.rvalid), 64'd0);
    chk("err_next_arready", 64'(up.arready), 64'd1);
    up.rready = 0;
    $display("txn: DECERR read addr=%h len=%0d id=%0d", addr, len, id);
  endtask

  initial begin
    vecs[0] = '{32'h8000_0004, 8'd3, 3'd2, 2'b01, 3'b001, 1'b1};
    vecs[1] = '{32'h1000_0000, 8'd0, 3'd2, 2'b01, 3'b010, 1'b0};
    vecs[2] = '{32'h1000_0000, 8'd1, 3'd2, 2'b01, 3'b000, 1'b1};
    vecs[3] = '{32'h1000_000C, 8'd0, 3'd1, 2'b01, 3'b000, 1'b1};
    vecs[4] = '{32'h1001_0004, 8'd0, 3'd2, 2'b01, 3'b100, 1'b1};
    vecs[5] = '{32'h1001_0008, 8'd0, 3'd2, 2'b01, 3'b000, 1'b1};
    vecs[6] = '{32'h2000_0000, 8'd0, 3'd2, 2'b01, 3'b000, 1'b1};
    vecs[7] = '{32'h87FF_FFFC, 8'd0, 3'd2, 2'b10, 3'b001, 1'b1};
    vecs[8] = '{32'h1000_0004, 8'd0, 3'd2, 2'b00, 3'b000, 1'b1};

    idle_all();
    // Reset: every valid/ready forced low even with requests pending.
    up.arvalid = 1; up.awvalid = 1; up.wvalid = 1; up.araddr = 32'h2000_0000;
    dn.m_rvalid = '1; dn.m_bvalid = '1;
    #2;
    chk("rst_arready", 64'(up.arready), 64'd0);
    chk("rst_awready", 64'(up.awready), 64'd0);
    chk("rst_wready", 64'(up.wready), 64'd0);
    chk("rst_rvalid", 64'(up.rvalid), 64'd0);
    chk("rst_bvalid", 64'(up.bvalid), 64'd0);
    @(posedge clk); #2 rst_n = 1;
    idle_all();

    // Address decode table applied to both AR and AW with no handshake completing.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      up.arvalid = 1; up.araddr = vecs[k].addr; up.arlen = vecs[k].len;
      up.arsize = vecs[k].size; up.arburst = vecs[k].burst; dn.m_arready = 3'b101;
      up.awvalid = 1; up.awaddr = vecs[k].addr; up.awlen = vecs[k].len;
      up.awsize = vecs[k].size; up.awburst = vecs[k].burst; dn.m_awready = 3'b101;
      #1;
      chk($sformatf("dec_ar_mvalid[%0d]", k), 64'(dn.m_arvalid), 64'(vecs[k].exp_mvalid));
      chk($sformatf("dec_arready[%0d]", k), 64'(up.arready), 64'(vecs[k].exp_ready));
      chk($sformatf("dec_aw_mvalid[%0d]", k), 64'(dn.m_awvalid), 64'(vecs[k].exp_mvalid));
      chk($sformatf("dec_awready[%0d]", k), 64'(up.awready), 64'(vecs[k].exp_ready));
      up.arvalid = 0; up.awvalid = 0;
      $display("txn: decode addr=%h len=%0d size=%0d burst=%0d", vecs[k].addr, vecs[k].len,
               vecs[k].size, vecs[k].burst);
    end
    idle_all();

    // SRAM 4-beat read with a UART single-beat write overlapping it.
    @(negedge clk);
    up.arvalid = 1; up.araddr = 32'h8000_0004; up.arid = 4'd2; up.arlen = 8'd3;
    dn.m_arready = 3'b001;
    up.awvalid = 1; up.awaddr = 32'h1000_0000; up.awid = 4'd7; up.awlen = 8'd0;
    dn.m_awready = 3'b010;
    #1;
    chk("rd_m_arvalid", 64'(dn.m_arvalid), 64'b001);
    chk("rd_arready", 64'(up.arready), 64'd1);
    chk("rd_m_araddr", 64'(dn.m_araddr), 64'h8000_0004);
    chk("wr_m_awvalid", 64'(dn.m_awvalid), 64'b010);
    chk("wr_awready", 64'(up.awready), 64'd1);
    @(negedge clk);
    up.arvalid = 0; up.awvalid = 0;
    up.rready = 1; dn.m_rvalid = 3'b001; dn.m_rdata[31:0] = 32'hA0; dn.m_rid[3:0] = 4'd2;
    up.wvalid = 1; up.wdata = 32'h55; up.wstrb = 4'hF; up.wlast = 1; dn.m_wready = 3'b010;
    #1;
    chk("rd_b0_rvalid", 64'(up.rvalid), 64'd1);
    chk("rd_b0_rdata", 64'(up.rdata), 64'hA0);
    chk("rd_b0_rid", 64'(up.rid), 64'd2);
    chk("rd_b0_rlast", 64'(up.rlast), 64'd0);
    chk("rd_m_rready", 64'(dn.m_rready), 64'b001);
    chk("rd_busy_arready", 64'(up.arready), 64'd0);
    chk("wr_m_wvalid", 64'(dn.m_wvalid), 64'b010);
    chk("wr_wready", 64'(up.wready), 64'd1);
    chk("wr_m_wdata", 64'(dn.m_wdata), 64'h55);
    @(negedge clk);
    up.wvalid = 0; up.wlast = 0; dn.m_rdata[31:0] = 32'hA1;
    up.bready = 1; dn.m_bvalid = 3'b010; dn.m_bresp[3:2] = 2'b00; dn.m_bid[7:4] = 4'd7;
    dn.m_bresp[1:0] = 2'b10; dn.m_bid[3:0] = 4'd1;
    #1;
    chk("wr_bvalid", 64'(up.bvalid), 64'd1);
    chk("wr_bresp", 64'(up.bresp), 64'd0);
    chk("wr_bid", 64'(up.bid), 64'd7);
    chk("wr_m_bready", 64'(dn.m_bready), 64'b010);
    chk("rd_b1_rdata", 64'(up.rdata), 64'hA1);
    chk("rd_b1_rlast", 64'(up.rlast), 64'd0);
    $display("txn: write UART addr=10000000 id=7 during SRAM burst");
    @(negedge clk);
    dn.m_bvalid = '0; dn.m_rdata[31:0] = 32'hA2;
    #1;
    chk("wr_done_bvalid", 64'(up.bvalid), 64'd0);
    chk("rd_b2_rdata", 64'(up.rdata), 64'hA2);
    chk("rd_b2_rlast", 64'(up.rlast), 64'd0);
    @(negedge clk);
    dn.m_rdata[31:0] = 32'hA3; dn.m_rlast = 3'b001;
    #1;
    chk("rd_b3_rdata", 64'(up.rdata), 64'hA3);
    chk("rd_b3_rlast", 64'(up.rlast), 64'd1);
    @(negedge clk);
    dn.m_rlast = '0; dn.m_arready = 3'b001; up.araddr = 32'h8000_0000;
    #1;
    chk("rd_done_rvalid", 64'(up.rvalid), 64'd0);
    chk("rd_done_m_rready", 64'(dn.m_rready), 64'd0);
    chk("rd_idle_arready", 64'(up.arready), 64'd1);
    $display("txn: SRAM read addr=80000004 len=3 id=2");
    idle_all();

    // DECERR reads: unmapped address, then a burst to the single-beat-only UART.
    err_read(32'h2000_0000, 8'd2, 4'd5, 1);
    err_read(32'h1000_0000, 8'd1, 4'd6, -1);

    // Write miss with early W (must stall until AW is taken), then sunk burst and DECERR B.
    @(negedge clk);
    up.wvalid = 1; up.wdata = 32'hDEAD;
    #1;
    chk("wmiss_early_wready", 64'(up.wready), 64'd0);
    @(negedge clk);
    up.awvalid = 1; up.awaddr = 32'h0; up.awlen = 8'd2; up.awid = 4'd9; dn.m_awready = '1;
    #1;
    chk("wmiss_awready", 64'(up.awready), 64'd1);
    chk("wmiss_m_awvalid", 64'(dn.m_awvalid), 64'd0);
    chk("wmiss_idle_wready", 64'(up.wready), 64'd0);
    @(negedge clk);
    up.awvalid = 0; dn.m_wready = '1;
    for (int b = 0; b < 3; b++) begin
      up.wlast = (b == 2);
      #1;
      chk($sformatf("wmiss_wready[%0d]", b), 64'(up.wready), 64'd1);
      chk($sformatf("wmiss_m_wvalid[%0d]", b), 64'(dn.m_wvalid), 64'd0);
      chk($sformatf("wmiss_bvalid[%0d]", b), 64'(up.bvalid), 64'd0);
      @(negedge clk);
    end
    up.wvalid = 0; up.wlast = 0; up.bready = 0;
    #1;
    chk("wmiss_bvalid", 64'(up.bvalid), 64'd1);
    chk("wmiss_bresp", 64'(up.bresp), 64'd3);
    chk("wmiss_bid", 64'(up.bid), 64'd9);
    chk("wmiss_sink_wready", 64'(up.wready), 64'd0);
    @(negedge clk);
    up.bready = 1;
    #1;
    chk("wmiss_hold_bvalid", 64'(up.bvalid), 64'd1);
    @(negedge clk);
    #1;
    chk("wmiss_done_bvalid", 64'(up.bvalid), 64'd0);
    chk("wmiss_next_awready", 64'(up.awready), 64'd1);
    $display("txn: DECERR write addr=00000000 len=2 id=9");
    idle_all();

    // Reset during beat 2 of a 4-beat SRAM read, then a clean CLINT read.
    @(negedge clk);
    up.arvalid = 1; up.araddr = 32'h8000_0000; up.arlen = 8'd3; dn.m_arready = 3'b001;
    @(negedge clk);
    up.arvalid = 0; up.rready = 1; dn.m_rvalid = 3'b001; dn.m_rdata[31:0] = 32'h11;
    #1;
    chk("rstb_b0_rvalid", 64'(up.rvalid), 64'd1);
    @(negedge clk);
    dn.m_rdata[31:0] = 32'h22; up.arvalid = 1; up.awvalid = 1; up.wvalid = 1;
    rst_n = 0;
    #1;
    chk("rstb_rvalid", 64'(up.rvalid), 64'd0);
    chk("rstb_m_rready", 64'(dn.m_rready), 64'd0);
    chk("rstb_arready", 64'(up.arready), 64'd0);
    chk("rstb_m_arvalid", 64'(dn.m_arvalid), 64'd0);
    chk("rstb_awready", 64'(up.awready), 64'd0);
    chk("rstb_wready", 64'(up.wready), 64'd0);
    @(posedge clk); #2 rst_n = 1;
    idle_all();
    @(negedge clk);
    up.arvalid = 1; up.araddr = 32'h1001_0000; up.arid = 4'd3; up.arlen = 8'd0;
    dn.m_arready = 3'b100; up.rready = 1;
    #1;
    chk("post_m_arvalid", 64'(dn.m_arvalid), 64'b100);
    chk("post_arready", 64'(up.arready), 64'd1);
    @(negedge clk);
    up.arvalid = 0; dn.m_rvalid = 3'b100; dn.m_rlast = 3'b100;
    dn.m_rdata[95:64] = 32'h00C0_FFEE; dn.m_rid[11:8] = 4'd3; dn.m_rresp[5:4] = 2'b00;
    dn.m_rdata[31:0] = 32'h99;
    #1;
    chk("post_rvalid", 64'(up.rvalid), 64'd1);
    chk("post_rdata", 64'(up.rdata), 64'h00C0_FFEE);
    chk("post_rid", 64'(up.rid), 64'd3);
    chk("post_rlast", 64'(up.rlast), 64'd1);
    chk("post_m_rready", 64'(dn.m_rready), 64'b100);
    @(negedge clk);
    dn.m_rvalid = '0;
    #1;
    chk("post_done_rvalid", 64'(up.rvalid), 64'd0);
    $display("txn: reset mid-burst then CLINT read addr=10010000 id=3");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
